t05_sram_responder: RTL and testbench
=====================================

T05_SRAM_RESPONDER -- requirements
Module: t05_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, memory depth in 32-bit words (power of two, 16..1024).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, wait-state count (1..7).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  write request from initiator.
REQ-007 SHALL have port r_en  input  1  read request from initiator.
REQ-008 SHALL have port addr  input  32  byte address of request.
REQ-009 SHALL have port sram_data_in  input  32  write data.
REQ-010 SHALL have port sel  input  4  byte enables, bit n = byte n; present only with T05_SRAM_RESP_BYTE_SEL_EN.
REQ-011 SHALL have port busy_o  output  1  high whenever FSM is not IDLE.
REQ-012 SHALL have port sram_data_out  output  32  read data, held until next completed read.
REQ-013 SHALL have port rd_valid  output  1  one-cycle pulse, sram_data_out freshly updated.
REQ-014 SHALL have port wr_done  output  1  one-cycle pulse, write committed.
REQ-015 SHALL have port addr_err  output  1  one-cycle pulse, request rejected.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAITREAD, DONE_R, WRITE, WAITWRITE, DONE_WR, ERR.
REQ-017 In IDLE, a rising edge with exactly one of r_en/wr_en high SHALL accept the request and latch addr, sram_data_in (and sel).
REQ-018 Request with r_en and wr_en both high SHALL go to ERR; no memory access.
REQ-019 Word index = (addr - BASE_ADDR) >> 2, computed in 32 bits; addr[1:0] != 0, addr < BASE_ADDR, or index >= DEPTH SHALL go to ERR.
REQ-020 Valid read: IDLE -> READ (1 cycle) -> WAITREAD (WAIT_CYCLES cycles, internal down-counter) -> DONE_R (1 cycle) -> IDLE.
REQ-021 Valid write: IDLE -> WRITE -> WAITWRITE (WAIT_CYCLES) -> DONE_WR -> IDLE; array updated on the edge leaving WAITWRITE.
REQ-022 ERR SHALL last 1 cycle, pulse addr_err, then return to IDLE; sram_data_out unchanged.
REQ-023 rd_valid SHALL be high only in DONE_R; wr_done only in DONE_WR; addr_err only in ERR.
REQ-024 Read latency: request accepted at edge N, rd_valid high in cycle N+2+WAIT_CYCLES; next request accepted no earlier than edge N+3+WAIT_CYCLES.
REQ-025 r_en/wr_en while busy_o high SHALL be ignored (not queued); initiator must hold or reissue.
REQ-026 Read of a word written earlier SHALL return the written value; read of never-written word returns 0 after reset-time init (REQ-030).
REQ-027 Inputs other than those latched in REQ-017 SHALL not affect an in-flight access.

Reset
REQ-028 rst SHALL force IDLE, clear wait counter and latched request, and drive busy_o=0, rd_valid=0, wr_done=0, addr_err=0, sram_data_out=0.
REQ-029 rst mid-operation SHALL abort the access; an uncommitted write SHALL not modify the array.
REQ-030 Memory array SHALL not be reset by rst; contents are zero-initialised at simulation start only.

Configuration
REQ-031 Macro T05_SRAM_RESP_BYTE_SEL_EN defined: sel port exists; write updates only bytes with sel bit high; sel=4'b0000 commits nothing but still pulses wr_done.
REQ-032 Macro undefined: no sel port; every write updates all 4 bytes.

Verification
REQ-033 Reset, then r_en=1, addr=32'h0000_0010 -> busy_o high 3 cycles, rd_valid pulse in cycle 3, sram_data_out=0.
REQ-034 wr_en=1, addr=32'h0000_0008, data=32'hDEAD_BEEF; after wr_done, read 32'h0000_0008 -> sram_data_out=32'hDEAD_BEEF, rd_valid one cycle.
REQ-035 addr=32'h0000_0402 (misaligned) and addr=32'h0000_0400 (index 256) -> addr_err one cycle each, no busy beyond 1 cycle, memory unchanged.
REQ-036 r_en=wr_en=1 in IDLE -> addr_err pulse; r_en held high during busy -> exactly one access, no second rd_valid until reissued from IDLE.
REQ-037 Assert rst during WAITWRITE of 32'h1234_5678 to word 4 -> outputs 0 next cycle; later read of word 4 returns prior value.
REQ-038 With T05_SRAM_RESP_BYTE_SEL_EN: word holds 32'hDEAD_BEEF, write 32'h0000_00AA with sel=4'b0001 -> read returns 32'hDEAD_BEAA.

Source files
------------

// File: rtl/t05_sram_responder.sv
// rtl/t05_sram_responder.sv - word-wide SRAM responder with wait states; optional byte enables via T05_SRAM_RESP_BYTE_SEL_EN
module t05_sram_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        r_en,
  input  logic [31:0] addr,
  input  logic [31:0] sram_data_in,
`ifdef T05_SRAM_RESP_BYTE_SEL_EN
  input  logic [3:0]  sel,
`endif
  output logic        busy_o,
  output logic [31:0] sram_data_out,
  output logic        rd_valid,
  output logic        wr_done,
  output logic        addr_err
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, READ, WAITREAD, DONE_R, WRITE, WAITWRITE, DONE_WR, ERR
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       wait_cnt;
  logic             wait_done;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      req_data;
`ifdef T05_SRAM_RESP_BYTE_SEL_EN
  logic [3:0]       req_sel;
`endif
  logic [31:0]      offset;
  logic [31:0]      word_idx;
  logic             addr_bad;
  logic             accept;
  logic             mem_we;

  // Contents start at zero once; rst deliberately leaves them alone.
  logic [31:0]      mem [DEPTH] = '{default: '0};

  // Decode the incoming address into a word index and reject unaligned or out-of-window requests.
  always_comb begin
    offset    = addr - BASE_ADDR;
    word_idx  = offset >> 2;
    addr_bad  = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || (word_idx >= DEPTH);
    accept    = (state == IDLE) && (r_en ^ wr_en);
    wait_done = (wait_cnt == 3'd0);
    mem_we    = (state == WAITWRITE) && wait_done && !rst;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and status outputs; new requests are only looked at in IDLE.
  always_comb begin
    state_nx = state;
    busy_o   = (state != IDLE);
    rd_valid = (state == DONE_R);
    wr_done  = (state == DONE_WR);
    addr_err = (state == ERR);
    case (state)
      IDLE: begin
        if (r_en && wr_en) state_nx = ERR;
        else if (r_en)     state_nx = addr_bad ? ERR : READ;
        else if (wr_en)    state_nx = addr_bad ? ERR : WRITE;
      end
      READ:      state_nx = WAITREAD;
      WAITREAD:  if (wait_done) state_nx = DONE_R;
      DONE_R:    state_nx = IDLE;
      WRITE:     state_nx = WAITWRITE;
      WAITWRITE: if (wait_done) state_nx = DONE_WR;
      DONE_WR:   state_nx = IDLE;
      ERR:       state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Wait-state down-counter, loaded on the way into the wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= 3'd0;
    else if (state == READ || state == WRITE)
      wait_cnt <= WAIT_LOAD;
    else if ((state == WAITREAD || state == WAITWRITE) && !wait_done)
      wait_cnt <= wait_cnt - 3'd1;
  end

  // Capture the request so later input changes cannot disturb the access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_idx  <= '0;
      req_data <= '0;
`ifdef T05_SRAM_RESP_BYTE_SEL_EN
      req_sel  <= '0;
`endif
    end else if (accept) begin
      req_idx  <= word_idx[IDX_W-1:0];
      req_data <= sram_data_in;
`ifdef T05_SRAM_RESP_BYTE_SEL_EN
      req_sel  <= sel;
`endif
    end
  end

  // Read data is refreshed on the edge entering DONE_R and held until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sram_data_out <= '0;
    else if (state == WAITREAD && wait_done)
      sram_data_out <= mem[req_idx];
  end

  // Commit the write on the edge leaving WAITWRITE; an aborted write never gets here.
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef T05_SRAM_RESP_BYTE_SEL_EN
      for (int b = 0; b < 4; b++)
        if (req_sel[b]) mem[req_idx][b*8 +: 8] <= req_data[b*8 +: 8];
`else
      mem[req_idx] <= req_data;
`endif
    end
  end

endmodule

// File: tb/tb_t05_sram_responder.sv
// tb/tb_t05_sram_responder.sv - table-driven bench for t05_sram_responder (default parameters)
module tb_t05_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        r_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] sram_data_in = '0;
`ifdef T05_SRAM_RESP_BYTE_SEL_EN
  logic [3:0]  sel = 4'hF;
`endif
  logic        busy_o;
  logic [31:0] sram_data_out;
  logic        rd_valid;
  logic        wr_done;
  logic        addr_err;

  int n_checks = 0;
  int n_errors = 0;

  t05_sram_responder dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .r_en(r_en),
    .addr(addr),
    .sram_data_in(sram_data_in),
`ifdef T05_SRAM_RESP_BYTE_SEL_EN
    .sel(sel),
`endif
    .busy_o(busy_o),
    .sram_data_out(sram_data_out),
    .rd_valid(rd_valid),
    .wr_done(wr_done),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  exp_pulse;  // {rd_valid, wr_done, addr_err}
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request: present before an edge, withdraw after it, then watch until busy drops.
  task automatic run_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int nbusy, output logic [2:0] pulses, output int npulse, output int pos);
    nbusy = 0; pulses = 3'b000; npulse = 0; pos = 0;
    @(negedge clk);
    r_en = r; wr_en = w; addr = a; sram_data_in = d;
    @(posedge clk);
    #1;
    r_en = 1'b0; wr_en = 1'b0; addr = 32'hFFFF_FFF1; sram_data_in = 32'h0BAD_0BAD;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy_o) break;
      nbusy++;
      if (rd_valid || wr_done || addr_err) begin
        npulse += int'(rd_valid) + int'(wr_done) + int'(addr_err);
        pos = nbusy;
      end
      pulses |= {rd_valid, wr_done, addr_err};
    end
  endtask

  initial begin
    int          nb, np, ps, rv;
    logic [2:0]  pl;
    int          exp_busy;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          3'b100, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF,  3'b010, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          3'b100, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0402, 32'h0,          3'b001, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,          3'b001, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0055,  3'b001, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0,          3'b001, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D,  3'b010, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,          3'b100, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          3'b100, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222,  3'b010, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          3'b100, 32'h1111_2222};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0009, 32'hFFFF_FFFF,  3'b001, 32'h1111_2222};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          3'b100, 32'h0000_0000};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          3'b100, 32'hDEAD_BEEF};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", {28'h0, busy_o, rd_valid, wr_done, addr_err, sram_data_out}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_req(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, nb, pl, np, ps);
      exp_busy = (vecs[i].exp_pulse == 3'b001) ? 1 : 3;
      check($sformatf("vec%0d_busy_cycles", i), 64'(nb), 64'(exp_busy));
      check($sformatf("vec%0d_pulse_kind", i), 64'(pl), 64'(vecs[i].exp_pulse));
      check($sformatf("vec%0d_pulse_count", i), 64'(np), 64'd1);
      check($sformatf("vec%0d_pulse_cycle", i), 64'(ps), 64'(exp_busy));
      check($sformatf("vec%0d_data_out", i), 64'(sram_data_out), 64'(vecs[i].exp_out));
    end

    // r_en held through the whole access: only one read happens.
    nb = 0; rv = 0;
    @(negedge clk);
    r_en = 1'b1; addr = 32'h0000_0008;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_o) nb++;
      if (rd_valid) begin
        rv++;
        r_en = 1'b0;
      end
    end
    r_en = 1'b0;
    check("held_ren_rd_valid_count", 64'(rv), 64'd1);
    check("held_ren_busy_cycles", 64'(nb), 64'd3);
    check("held_ren_data", 64'(sram_data_out), 64'hDEAD_BEEF);

    // Reset asserted during WAITWRITE aborts the write to word 4.
    @(negedge clk);
    wr_en = 1'b1; addr = 32'h0000_0010; sram_data_in = 32'h1234_5678;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_in_waitwrite", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy_async", 64'(busy_o), 64'd0);
    @(negedge clk);
    check("abort_outputs_zero", {28'h0, busy_o, rd_valid, wr_done, addr_err, sram_data_out}, 64'h0);
    rst = 1'b0;
    run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, nb, pl, np, ps);
    check("abort_readback_kind", 64'(pl), 64'b100);
    check("abort_readback_data", 64'(sram_data_out), 64'h1111_2222);

`ifdef T05_SRAM_RESP_BYTE_SEL_EN
    sel = 4'b0001;
    run_req(1'b0, 1'b1, 32'h0000_0008, 32'h0000_00AA, nb, pl, np, ps);
    check("bytesel_write_kind", 64'(pl), 64'b010);
    sel = 4'b0000;
    run_req(1'b0, 1'b1, 32'h0000_0008, 32'h5555_5555, nb, pl, np, ps);
    check("bytesel_none_kind", 64'(pl), 64'b010);
    sel = 4'hF;
    run_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, nb, pl, np, ps);
    check("bytesel_readback", 64'(sram_data_out), 64'hDEAD_BEAA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
